// File: rtl/mic_level_encoder.sv
// Peak-over-window microphone level meter producing a 0..16 bar level and its thermometer code.
// Optional build macro METER_DECAY_EN: bar rises instantly but falls one level per window.
module mic_level_encoder #(
  parameter int WINDOW   = 4000,
  parameter int BASELINE = 2048,
  parameter int STEP     = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  input  logic        hold,
  output logic [15:0] tester,
  output logic [4:0]  level,
  output logic        update
);

  localparam int             CW   = $clog2(WINDOW);
  localparam logic [CW-1:0]  LAST = CW'(WINDOW - 1);
  localparam logic [11:0]    BASE = 12'(BASELINE);

  logic [CW-1:0] count;
  logic [11:0]   peak;
  logic [11:0]   m;
  logic [11:0]   amp;
  logic [4:0]    new_lvl;
  logic [4:0]    lvl_next;
  logic [15:0]   therm_next;
  logic          accept;
  logic          last_sample;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    accept      = sample_valid & ~hold;
    last_sample = accept && (count == LAST);
    m           = (mic_in > peak) ? mic_in : peak;
    amp         = (m > BASE) ? (m - BASE) : '0;

    // Threshold ladder instead of a divider; the highest passed rung wins and 16 is the cap.
    new_lvl = '0;
    for (int k = 1; k <= 16; k++) begin
      if (32'(amp) >= 32'(k * STEP)) new_lvl = 5'(k);
    end

`ifdef METER_DECAY_EN
    lvl_next = (new_lvl >= level) ? new_lvl : (level - 5'd1);
`else
    lvl_next = new_lvl;
`endif

    therm_next = '0;
    for (int i = 0; i < 16; i++) begin
      therm_next[i] = (5'(i) < lvl_next);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      peak   <= '0;
      level  <= '0;
      tester <= '0;
      update <= 1'b0;
    end else begin
      update <= last_sample;
      if (accept) begin
        if (last_sample) begin
          level  <= lvl_next;
          tester <= therm_next;
          peak   <= '0;
          count  <= '0;
        end else begin
          peak  <= m;
          count <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_level_encoder.sv
// Scoreboard bench for mic_level_encoder with a 4-sample window; expectations come from a
// division-based reference model, plus fixed per-scenario level/tester constants.
module tb_mic_level_encoder;

  localparam int WINDOW   = 4;
  localparam int BASELINE = 2048;
  localparam int STEP     = 120;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] mic_in = '0;
  logic        hold = 1'b0;
  logic [15:0] tester;
  logic [4:0]  level;
  logic        update;

  mic_level_encoder #(.WINDOW(WINDOW), .BASELINE(BASELINE), .STEP(STEP)) dut (
    .clock(clock), .resetn(resetn), .sample_valid(sample_valid), .mic_in(mic_in),
    .hold(hold), .tester(tester), .level(level), .update(update)
  );

  always #5 clock = ~clock;

  int          n_pass = 0;
  int          n_total = 0;
  int          update_cnt = 0;
  logic [20:0] exp_q[$];
  logic [20:0] exp_e;

  int          m_count = 0;
  int          m_peak = 0;
  int          m_level = 0;

  function automatic int popcnt16(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Reference model of one accepted sample; pushes the expected result at window end.
  task automatic model_accept(input logic [11:0] s);
    int amp, lvl;
    logic [31:0] th;
    if (int'(s) > m_peak) m_peak = int'(s);
    if (m_count == WINDOW - 1) begin
      amp = (m_peak > BASELINE) ? m_peak - BASELINE : 0;
      lvl = amp / STEP;
      if (lvl > 16) lvl = 16;
`ifdef METER_DECAY_EN
      if (lvl < m_level) lvl = m_level - 1;
`endif
      m_level = lvl;
      th = (32'd1 << lvl) - 32'd1;
      exp_q.push_back({5'(lvl), th[15:0]});
      m_count = 0;
      m_peak  = 0;
    end else begin
      m_count++;
    end
  endtask

  // Output monitor: every update pulse must match the next scoreboard entry.
  always @(negedge clock) begin
    if (resetn && update) begin
      update_cnt++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_update: level=%0d tester=%h, no window end pending", level, tester);
      end else begin
        exp_e = exp_q.pop_front();
        if ({level, tester} !== exp_e)
          $display("FAIL window_result: got level=%0d tester=%h, expected level=%0d tester=%h",
                   level, tester, exp_e[20:16], exp_e[15:0]);
        else n_pass++;
      end
      n_total++;
      if (popcnt16(tester) != int'(level) || ((tester + 16'd1) & tester) != 16'd0)
        $display("FAIL consistency: tester=%h level=%0d", tester, level);
      else n_pass++;
    end
  end

  task automatic send(input logic [11:0] s);
    @(negedge clock);
    sample_valid = 1'b1;
    mic_in = s;
    if (!hold) model_accept(s);
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  task automatic send_window(input logic [11:0] s);
    for (int i = 0; i < WINDOW; i++) send(s);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL %s_timeout: %0d window results still pending, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_peak = 0;
    m_level = 0;
    @(negedge clock);
    n_total++;
    if (tester !== 16'h0000 || level !== 5'd0 || update !== 1'b0)
      $display("FAIL reset_state: tester=%h level=%0d update=%b, expected 0000/0/0", tester, level, update);
    else n_pass++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    int snap;
    do_reset();
    send(12'd4095);
    send(12'd4095);
    do_reset();
    snap = update_cnt;
    for (int i = 0; i < 3; i++) send(12'd2048);
    n_total++;
    if (update_cnt != snap)
      $display("FAIL reset_early_update: got %0d pulses, expected 0", update_cnt - snap);
    else n_pass++;
    send(12'd2048);
    drain("reset");
    n_total++;
    if (update_cnt != snap + 1 || level !== 5'd0 || tester !== 16'h0000)
      $display("FAIL reset_window: pulses=%0d level=%0d tester=%h, expected 1/0/0000",
               update_cnt - snap, level, tester);
    else n_pass++;
  endtask

  task automatic test_mapping();
    do_reset();
    send(12'd2048);
    send(12'd2100);
    send(12'd2300);
    send(12'd2048);
    n_total++;
    if (update !== 1'b1)
      $display("FAIL mapping_latency: update=%b one cycle after last strobe, expected 1", update);
    else n_pass++;
    drain("mapping");
    n_total++;
    if (level !== 5'd2 || tester !== 16'h0003 || update !== 1'b0)
      $display("FAIL mapping_value: level=%0d tester=%h update=%b, expected 2/0003/0", level, tester, update);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    send_window(12'd4095);
    drain("saturation");
    n_total++;
    if (level !== 5'd16 || tester !== 16'hFFFF)
      $display("FAIL saturation: level=%0d tester=%h, expected 16/FFFF", level, tester);
    else n_pass++;
  endtask

  task automatic test_below_baseline();
    do_reset();
    send_window(12'd1000);
    drain("below_base");
    n_total++;
    if (level !== 5'd0 || tester !== 16'h0000)
      $display("FAIL below_baseline: level=%0d tester=%h, expected 0/0000", level, tester);
    else n_pass++;
    send_window(12'(BASELINE + STEP * 7));
    drain("step7");
    n_total++;
    if (level !== 5'd7 || tester !== 16'h007F)
      $display("FAIL step7: level=%0d tester=%h, expected 7/007F", level, tester);
    else n_pass++;
  endtask

  task automatic test_hold();
    int snap;
    do_reset();
    send(12'd2048);
    send(12'd2048);
    snap = update_cnt;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) send(12'd4095);
    @(negedge clock);
    n_total++;
    if (update_cnt != snap || level !== 5'd0 || tester !== 16'h0000)
      $display("FAIL hold_frozen: pulses=%0d level=%0d tester=%h, expected 0/0/0000",
               update_cnt - snap, level, tester);
    else n_pass++;
    hold = 1'b0;
    send(12'(BASELINE + STEP * 3));
    n_total++;
    if (update_cnt != snap)
      $display("FAIL hold_count: early update after 3 accepted samples, expected none");
    else n_pass++;
    send(12'd2048);
    drain("hold");
    n_total++;
    if (update_cnt != snap + 1 || level !== 5'd3 || tester !== 16'h0007)
      $display("FAIL hold_result: pulses=%0d level=%0d tester=%h, expected 1/3/0007",
               update_cnt - snap, level, tester);
    else n_pass++;
  endtask

  task automatic test_decay();
    do_reset();
    send_window(12'd4095);
    drain("decay_peak");
    send_window(12'd2048);
    drain("decay_quiet1");
    n_total++;
`ifdef METER_DECAY_EN
    if (level !== 5'd15 || tester !== 16'h7FFF)
      $display("FAIL decay_first: level=%0d tester=%h, expected 15/7FFF", level, tester);
`else
    if (level !== 5'd0 || tester !== 16'h0000)
      $display("FAIL decay_first: level=%0d tester=%h, expected 0/0000", level, tester);
`endif
    else n_pass++;
    send_window(12'd2048);
    drain("decay_quiet2");
    n_total++;
`ifdef METER_DECAY_EN
    if (level !== 5'd14 || tester !== 16'h3FFF)
      $display("FAIL decay_second: level=%0d tester=%h, expected 14/3FFF", level, tester);
`else
    if (level !== 5'd0 || tester !== 16'h0000)
      $display("FAIL decay_second: level=%0d tester=%h, expected 0/0000", level, tester);
`endif
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int snap;
    logic [11:0] vals [8];
    vals = '{12'd2100, 12'd2650, 12'd2048, 12'd2300, 12'd3008, 12'd1500, 12'd2500, 12'd2900};
    do_reset();
    snap = update_cnt;
    @(negedge clock);
    sample_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mic_in = vals[i];
      model_accept(vals[i]);
      @(negedge clock);
    end
    sample_valid = 1'b0;
    drain("back_to_back");
    n_total++;
    if (update_cnt != snap + 2 || level !== 5'd8 || tester !== 16'h00FF)
      $display("FAIL back_to_back: pulses=%0d level=%0d tester=%h, expected 2/8/00FF",
               update_cnt - snap, level, tester);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mapping();
    test_saturation();
    test_below_baseline();
    test_hold();
    test_decay();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mic_level_encoder.md
Name: mic_level_encoder

Overview:
- Converts the raw 12-bit microphone sample stream into the 16-bit thermometer bar code consumed by the OLED soundbar renderer.
- Tracks the peak sample over a fixed window of accepted samples, then maps peak amplitude above the mic baseline to a level 0..16.
- Publishes the level as binary and as a thermometer code, plus a one-cycle update strobe.
- Sits between the mic ADC sampling block and the soundbar display blocks.

Parameters:
- WINDOW, 4000, accepted samples per measurement window (0.2 s at 20 kHz); legal range >= 2.
- BASELINE, 2048, ADC code for silence.
- STEP, 120, amplitude codes per bar level.

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- sample_valid  input  1  single-cycle strobe; `mic_in` is valid this cycle.
- mic_in  input  12  unsigned ADC sample.
- hold  input  1  freeze: while high, samples are ignored and outputs are held.
- tester  output  16  thermometer code: lower `level` bits set, others 0.
- level  output  5  binary level 0..16.
- update  output  1  one-cycle pulse when `level`/`tester` are refreshed.

Behaviour:
- Reset (async, resetn=0): `tester`=16'h0000, `level`=0, `update`=0, window count=0, peak register=0. Deassertion is synchronous to `clock` via the normal flop path.
- Accepted sample: the rising edge where sample_valid=1 and hold=0. Ignored otherwise. When hold=1, count, peak and outputs are unchanged.
- Window count: 0..WINDOW-1, increments on each accepted sample.
- Non-final accepted sample (count < WINDOW-1): peak <= max(peak, mic_in); count <= count+1.
- Final accepted sample (count == WINDOW-1):
  - m = max(peak, mic_in).
  - amp = (m > BASELINE) ? m-BASELINE : 0, 12-bit unsigned.
  - newlvl = min(16, floor(amp/STEP)), computed via a compare chain amp >= k*STEP for k = 1..16; no divider.
  - Registered on the same edge: level <= newlvl; tester <= (1<<newlvl)-1 (newlvl=16 gives 16'hFFFF); update <= 1; peak <= 0; count <= 0.
  - Latency: outputs valid in the cycle after the final sample's edge.
- update: high for exactly one cycle per completed window, 0 otherwise, including while hold=1.
- Outputs hold their value between windows. No partial-window output.
- The window restarts cleanly after reset mid-window. Partial peak and count are discarded.
- tester and level are always consistent: popcount(tester)==level, contiguous from bit 0.
- Back-to-back sample_valid on consecutive cycles is supported.

Optional Feature:
- Macro: METER_DECAY_EN.
- Defined: at window end, if newlvl >= level then level <= newlvl, else level <= level-1. The bar rises instantly and falls one level per window. tester follows level.
- Undefined: level <= newlvl unconditionally.

Test Plan:
- Reset: assert resetn=0 mid-window with WINDOW=4 after 2 samples, release, then feed 4 samples of 2048 -> tester=16'h0000, level=0, exactly one update pulse after the 4th sample, none earlier.
- Window mapping, WINDOW=4: samples 2048, 2100, 2300, 2048 -> amp=252, level=2, tester=16'h0003, update high one cycle after the 4th strobe.
- Saturation: 4 samples of 4095 -> amp=2047, floor(2047/120)=17 clamped -> level=16, tester=16'hFFFF.
- Below baseline: 4 samples of 1000 -> level=0, tester=16'h0000. Then a window of 2048+STEP*7=2888 -> level=7, tester=16'h007F.
- Hold: hold=1 while issuing 3 strobes mid-window (after 2 accepted) -> count unchanged, no update. Release hold; 2 more samples complete the window. Strobes issued during hold do not affect peak.
- Decay: window at 4095 (level 16), then window at 2048 -> without METER_DECAY_EN level=0, tester=16'h0000; with it level=15, tester=16'h7FFF, next quiet window 14/16'h3FFF.
